axilite_wr_arbiter: RTL
=======================

# axilite_wr_arbiter

Round-robin arbiter that shares one AXI-Lite write master port (AW/W/B) of the NoC–AXI-Lite bridge between NUM_REQ upstream write requesters, such as traffic generators and the config path. One write transaction is outstanding on the shared port at a time. The arbiter forwards the granted requester's address and data, then routes the write response back to that requester only.

## Interface
- NUM_REQ, 2: number of requesters (2..8).
- AXILITE_ADDR_WIDTH, 64: address width.
- AXILITE_DATA_WIDTH, 64: data width.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  NUM_REQ*AXILITE_ADDR_WIDTH  per-requester write address; requester i at slice [i*AW +: AW].
- s_axi_awvalid  in  NUM_REQ  per-requester address valid.
- s_axi_awready  out  NUM_REQ  per-requester address ready.
- s_axi_wdata  in  NUM_REQ*AXILITE_DATA_WIDTH  per-requester write data.
- s_axi_wvalid  in  NUM_REQ  per-requester data valid.
- s_axi_wready  out  NUM_REQ  per-requester data ready.
- s_axi_bresp  out  2  write response, shared bus; meaningful only when the matching bvalid bit is set.
- s_axi_bvalid  out  NUM_REQ  per-requester response valid.
- s_axi_bready  in  NUM_REQ  per-requester response ready.
- m_axi_awaddr  out  AXILITE_ADDR_WIDTH  shared address.
- m_axi_awvalid  out  1  shared address valid.
- m_axi_awready  in  1  shared address ready.
- m_axi_wdata  out  AXILITE_DATA_WIDTH  shared data.
- m_axi_wvalid  out  1  shared data valid.
- m_axi_wready  in  1  shared data ready.
- m_axi_bresp  in  2  shared response code.
- m_axi_bvalid  in  1  shared response valid.
- m_axi_bready  out  1  shared response ready.

## Operation
- FSM states: IDLE, XFER, RESP. The state register, grant register (log2 NUM_REQ bits), aw_done and w_done flags, and the last-grant pointer all reset asynchronously. Reset values: IDLE, grant 0, flags 0, last-grant pointer NUM_REQ-1.
- IDLE: a requester is eligible when its s_axi_awvalid[i] is 1. Among eligible requesters, pick the first one found scanning upward from (last_grant+1) mod NUM_REQ. Latch it into grant, clear both flags, and go to XFER. With no eligible requester, stay in IDLE.
- XFER, address path: m_axi_aw* = requester grant's aw* with valid masked by !aw_done. The requester's awready = m_axi_awready & !aw_done.
- XFER, data path: m_axi_w* = requester grant's w* with valid masked by !w_done. The requester's wready = m_axi_wready & !w_done.
- XFER, completion tracking: set aw_done on AW fire and w_done on W fire. AW and W may fire in either order or in the same cycle. Go to RESP in the cycle where both are, or become, done.
- RESP: m_axi_bready = s_axi_bready[grant]. s_axi_bvalid[grant] = m_axi_bvalid. s_axi_bresp = m_axi_bresp. On B fire, set last_grant = grant and go to IDLE.
- In all other states, and for every non-granted requester, all ready and valid outputs are 0.
- m_axi_bvalid arriving outside RESP is a slave protocol error. It is ignored and m_axi_bready is held at 0.
- Deasserting a requester's valid after it is granted is an AXI violation; the behaviour is undefined and is not checked.
- Reset asserted mid-transaction: all outputs drop to 0 asynchronously and the in-flight transaction is abandoned. After reset releases, requester 0 has the highest priority.

## Timing
- Every output is 0 during reset. All outputs are combinational from the registered state, grant and flags plus the input handshakes. There is no combinational path from s_axi_*valid to m_axi_*valid while in IDLE.
- Arbitration latency: a request is sampled in IDLE at cycle 0, and m_axi_awvalid and m_axi_wvalid are asserted at cycle 1.
- Minimum transaction: IDLE (1 cycle), XFER (1 cycle with both fires together), RESP (1 cycle with an immediate B fire). That gives a 3-cycle back-to-back period per transaction.
- RESP holds indefinitely while m_axi_bvalid or s_axi_bready[grant] is low. XFER holds indefinitely while AW or W has not fired.

## Structure
- Shared package axilite_arb_pkg: FSM state encoding, the AXI-Lite resp width (2), and the response constants OKAY=2'b00 and SLVERR=2'b10.
- Sub-module rr_arbiter (NUM_REQ request vector plus pointer in, one-hot and index grant out, purely combinational). It is reusable for a later read-channel arbiter.

## Test plan
- Single write: req0 sends awaddr=0x80000000, wdata=0x1 with ready and bready tied high. The shared port shows the same values at cycle 1, bvalid[0] is seen at cycle 2, and bvalid[1] stays 0 throughout.
- Contention: req0 and req1 hold valid continuously for 6 transactions with wdata equal to the requester id. Grants alternate 0,1,0,1,0,1 and no requester is starved.
- Split handshake: the slave raises m_axi_wready 3 cycles after m_axi_awready. Exactly one AW fire and one W fire occur, m_axi_awvalid drops after its fire, and RESP is entered one cycle after the W fire.
- Response routing: req1 is granted and the slave returns bresp=SLVERR with s_axi_bready[1] held low for 4 cycles. The arbiter stays in RESP, and s_axi_bresp=2'b10 appears only with bvalid[1].
- Reset mid-XFER: assert rst_n=0 after the AW fire but before the W fire. All outputs go to 0 immediately. After release, simultaneous req0 and req1 results in req0 being granted first.
- Stray bvalid: pulse m_axi_bvalid in IDLE. m_axi_bready stays 0, all s_axi_bvalid bits stay 0, and the state stays IDLE.

Source files
------------

// File: rtl/axilite_arb_pkg.sv
// Shared definitions for the AXI-Lite write-channel arbiter: FSM encoding and response codes.
package axilite_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  localparam int unsigned RespWidth = 2;

  localparam logic [RespWidth-1:0] RespOkay   = 2'b00;
  localparam logic [RespWidth-1:0] RespSlverr = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning upward from ptr+1 (mod NUM_REQ).
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int unsigned IdxWidth = $clog2(NUM_REQ);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr) + 32'd1 + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IdxWidth'(cand);
      end
    end
  end

endmodule

// File: rtl/axilite_wr_arbiter.sv
// Round-robin sharing of one AXI-Lite write port (AW/W/B) among NUM_REQ requesters,
// one outstanding transaction at a time, with the B response routed to the granted requester.
module axilite_wr_arbiter
  import axilite_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ            = 2,
  parameter int unsigned AXILITE_ADDR_WIDTH = 64,
  parameter int unsigned AXILITE_DATA_WIDTH = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ*AXILITE_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [NUM_REQ-1:0]                    s_axi_awvalid,
  output logic [NUM_REQ-1:0]                    s_axi_awready,
  input  logic [NUM_REQ*AXILITE_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [NUM_REQ-1:0]                    s_axi_wvalid,
  output logic [NUM_REQ-1:0]                    s_axi_wready,
  output logic [RespWidth-1:0]                  s_axi_bresp,
  output logic [NUM_REQ-1:0]                    s_axi_bvalid,
  input  logic [NUM_REQ-1:0]                    s_axi_bready,
  output logic [AXILITE_ADDR_WIDTH-1:0]         m_axi_awaddr,
  output logic                                  m_axi_awvalid,
  input  logic                                  m_axi_awready,
  output logic [AXILITE_DATA_WIDTH-1:0]         m_axi_wdata,
  output logic                                  m_axi_wvalid,
  input  logic                                  m_axi_wready,
  input  logic [RespWidth-1:0]                  m_axi_bresp,
  input  logic                                  m_axi_bvalid,
  output logic                                  m_axi_bready
);

  localparam int unsigned GntWidth = $clog2(NUM_REQ);
  localparam int unsigned AW       = AXILITE_ADDR_WIDTH;
  localparam int unsigned DW       = AXILITE_DATA_WIDTH;

  arb_state_e          state_q, state_d;
  logic [GntWidth-1:0] grant_q, grant_d;
  logic [GntWidth-1:0] last_q, last_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [GntWidth-1:0] arb_idx;
  logic [AW-1:0]       sel_awaddr;
  logic [DW-1:0]       sel_wdata;
  logic                aw_fire, w_fire;

  // Only awvalid qualifies a requester; its W beat is expected to follow on the same grant.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (s_axi_awvalid),
    .ptr     (last_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign sel_awaddr = s_axi_awaddr[32'(grant_q)*AW +: AW];
  assign sel_wdata  = s_axi_wdata[32'(grant_q)*DW +: DW];

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    aw_fire       = 1'b0;
    w_fire        = 1'b0;
    s_axi_awready = '0;
    s_axi_wready  = '0;
    s_axi_bvalid  = '0;
    s_axi_bresp   = RespOkay;
    m_axi_awaddr  = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|arb_gnt) begin
          grant_d   = arb_idx;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StXfer;
        end
      end

      StXfer: begin
        m_axi_awaddr           = sel_awaddr;
        m_axi_awvalid          = s_axi_awvalid[grant_q] & ~aw_done_q;
        s_axi_awready[grant_q] = m_axi_awready & ~aw_done_q;
        m_axi_wdata            = sel_wdata;
        m_axi_wvalid           = s_axi_wvalid[grant_q] & ~w_done_q;
        s_axi_wready[grant_q]  = m_axi_wready & ~w_done_q;

        aw_fire   = s_axi_awvalid[grant_q] & ~aw_done_q & m_axi_awready;
        w_fire    = s_axi_wvalid[grant_q] & ~w_done_q & m_axi_wready;
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (aw_done_d && w_done_d) begin
          state_d = StResp;
        end
      end

      StResp: begin
        m_axi_bready          = s_axi_bready[grant_q];
        s_axi_bvalid[grant_q] = m_axi_bvalid;
        // Keep the shared bresp quiet unless a response is actually being presented.
        if (m_axi_bvalid) begin
          s_axi_bresp = m_axi_bresp;
        end
        if (m_axi_bvalid && s_axi_bready[grant_q]) begin
          last_d  = grant_q;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      last_q    <= GntWidth'(NUM_REQ - 1);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule
